// File: rtl/rasterint_multi_ctrl_pkg.sv
// Shared constants for the multi-channel raster interrupt controller:
// register offsets, control-bit positions and the pulse FSM encoding.
package rasterint_multi_ctrl_pkg;

    localparam int unsigned LINE_OFS = 0;
    localparam int unsigned CTRL_OFS = 1;

    localparam int unsigned CTRL_LINE8_BIT  = 0;
    localparam int unsigned CTRL_EN_BIT     = 1;
    localparam int unsigned GCTRL_VRDIS_BIT = 0;
    localparam int unsigned GCTRL_RIP_BIT   = 7;

    function automatic int unsigned status_ofs(input int unsigned nchan);
        return 2 * nchan;
    endfunction

    function automatic int unsigned gctrl_ofs(input int unsigned nchan);
        return 2 * nchan + 1;
    endfunction

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

endpackage

// File: rtl/rasterint_channel.sv
// One raster comparator channel: programmable line, enable, and a
// rising-edge match detector so a stalled beam position yields one event.
module rasterint_channel
    import rasterint_multi_ctrl_pkg::*;
#(
    parameter logic [8:0] HTRIGGER = 9'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_line_i,
    input  logic       wr_ctrl_i,
    input  logic [7:0] din_i,
    input  logic [8:0] hc_i,
    input  logic [8:0] vc_i,
    output logic [8:0] line_o,
    output logic       en_o,
    output logic       event_o
);

    logic [8:0] line_q, line_d;
    logic       en_q, en_d;
    logic       match, match_q;

    always_comb begin
        line_d = line_q;
        en_d   = en_q;
        if (wr_line_i) begin
            line_d[7:0] = din_i;
        end
        if (wr_ctrl_i) begin
            line_d[8] = din_i[CTRL_LINE8_BIT];
            en_d      = din_i[CTRL_EN_BIT];
        end
    end

    assign match   = en_q & (vc_i == line_q) & (hc_i == HTRIGGER);
    assign event_o = match & ~match_q;
    assign line_o  = line_q;
    assign en_o    = en_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q  <= 9'h1FF;
            en_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            en_q    <= en_d;
            match_q <= match;
        end
    end

endmodule

// File: rtl/rasterint_multi_ctrl.sv
// Multi-channel raster interrupt controller on the ZX-UNO register bus:
// NCHAN line comparators plus vertical retrace sharing one int_n pulse.
module rasterint_multi_ctrl
    import rasterint_multi_ctrl_pkg::*;
#(
    parameter int unsigned NCHAN         = 4,
    parameter logic [7:0]  BASEADDR      = 8'h40,
    parameter logic [8:0]  HTRIGGER      = 9'd0,
    parameter logic [8:0]  VRETRACE_LINE = 9'd248,
    parameter int unsigned INT_LEN       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       zxuno_addr,
    input  logic             zxuno_regrd,
    input  logic             zxuno_regwr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             oe_n,
    input  logic [8:0]       hc,
    input  logic [8:0]       vc,
    output logic             int_n,
    output logic             raster_int_in_progress,
    output logic [NCHAN-1:0] pending
);

    localparam int unsigned CW       = $clog2(INT_LEN + 1);
    localparam logic [7:0]  STATUS_A = 8'(status_ofs(NCHAN));
    localparam logic [7:0]  GCTRL_A  = 8'(gctrl_ofs(NCHAN));

    logic [7:0]       ofs;
    logic             sel, wr_en;
    logic [8:0]       line [NCHAN];
    logic [NCHAN-1:0] en, ch_event;
    logic [NCHAN-1:0] pending_q, pending_d;
    logic             vrdis_q, vrdis_d;
    logic             match_v, match_v_q, v_event;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rip_q, rip_d;

    assign ofs   = zxuno_addr - BASEADDR;
    assign sel   = (zxuno_addr >= BASEADDR) && (ofs <= GCTRL_A);
    assign wr_en = zxuno_regwr && sel;

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        localparam logic [7:0] LineA = 8'(2 * k + LINE_OFS);
        localparam logic [7:0] CtrlA = 8'(2 * k + CTRL_OFS);

        rasterint_channel #(
            .HTRIGGER(HTRIGGER)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_line_i(wr_en && (ofs == LineA)),
            .wr_ctrl_i(wr_en && (ofs == CtrlA)),
            .din_i    (din),
            .hc_i     (hc),
            .vc_i     (vc),
            .line_o   (line[k]),
            .en_o     (en[k]),
            .event_o  (ch_event[k])
        );
    end

    assign match_v = ~vrdis_q & (vc == VRETRACE_LINE) & (hc == HTRIGGER);
    assign v_event = match_v & ~match_v_q;

    // A new event outranks a same-cycle write-1-clear.
    always_comb begin
        pending_d = pending_q;
        vrdis_d   = vrdis_q;
        if (wr_en && (ofs == STATUS_A)) begin
            pending_d = pending_q & ~din[NCHAN-1:0];
        end
        if (wr_en && (ofs == GCTRL_A)) begin
            vrdis_d = din[GCTRL_VRDIS_BIT];
        end
        pending_d = pending_d | ch_event;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rip_d   = rip_q;
        case (state_q)
            StIdle: begin
                if ((|ch_event) || v_event) begin
                    state_d = StActive;
                    cnt_d   = CW'(INT_LEN - 1);
                    rip_d   = |ch_event;
                end
            end
            StActive: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    rip_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            vrdis_q   <= 1'b0;
            match_v_q <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            rip_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            vrdis_q   <= vrdis_d;
            match_v_q <= match_v;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rip_q     <= rip_d;
        end
    end

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (zxuno_regrd && sel) begin
            oe_n = 1'b0;
            dout = 8'h00;
            for (int k = 0; k < NCHAN; k++) begin
                if (ofs == 8'(2 * k + LINE_OFS)) begin
                    dout = line[k][7:0];
                end
                if (ofs == 8'(2 * k + CTRL_OFS)) begin
                    dout[CTRL_LINE8_BIT] = line[k][8];
                    dout[CTRL_EN_BIT]    = en[k];
                end
            end
            if (ofs == STATUS_A) begin
                dout[NCHAN-1:0] = pending_q;
            end
            if (ofs == GCTRL_A) begin
                dout[GCTRL_VRDIS_BIT] = vrdis_q;
                dout[GCTRL_RIP_BIT]   = rip_q;
            end
        end
    end

    assign int_n                  = (state_q != StActive);
    assign raster_int_in_progress = rip_q;
    assign pending                = pending_q;

endmodule

// File: tb/tb_rasterint_multi_ctrl.sv
// Directed self-checking bench for rasterint_multi_ctrl (NCHAN=4, base 0x40,
// INT_LEN=32); expected values are hand-computed constants.
module tb_rasterint_multi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] zxuno_addr, din, dout;
    logic       zxuno_regrd, zxuno_regwr, oe_n;
    logic [8:0] hc, vc;
    logic       int_n, rip;
    logic [3:0] pending;

    int nchecks = 0;
    int nerrs   = 0;
    int w, falls, lowc, vfall;

    rasterint_multi_ctrl #(
        .NCHAN        (4),
        .BASEADDR     (8'h40),
        .HTRIGGER     (9'd0),
        .VRETRACE_LINE(9'd248),
        .INT_LEN      (32)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .zxuno_addr            (zxuno_addr),
        .zxuno_regrd           (zxuno_regrd),
        .zxuno_regwr           (zxuno_regwr),
        .din                   (din),
        .dout                  (dout),
        .oe_n                  (oe_n),
        .hc                    (hc),
        .vc                    (vc),
        .int_n                 (int_n),
        .raster_int_in_progress(rip),
        .pending               (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerrs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        zxuno_addr  = a;
        din         = d;
        zxuno_regwr = 1'b1;
        step(1);
        zxuno_regwr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp,
                      input logic exp_oe_n);
        zxuno_addr  = a;
        zxuno_regrd = 1'b1;
        #1;
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_oe_n"}, 32'(oe_n), 32'(exp_oe_n));
        zxuno_regrd = 1'b0;
    endtask

    // Counts remaining low cycles of the current pulse, bounded.
    task automatic measure(output int width);
        width = 0;
        while (int_n === 1'b0 && width < 200) begin
            width++;
            step(1);
        end
    endtask

    // Two cycles per line (hc=0 then hc=1) across a 312-line frame.
    task automatic sweep(output int nfall, output int nlow, output int vf);
        logic prev;
        nfall = 0;
        nlow  = 0;
        vf    = -1;
        prev  = int_n;
        for (int v = 0; v < 312; v++) begin
            vc = 9'(v);
            for (int h = 0; h < 2; h++) begin
                hc = 9'(h);
                step(1);
                if (prev && !int_n) begin
                    nfall++;
                    vf = v;
                end
                if (!int_n) nlow++;
                prev = int_n;
            end
        end
        vc = 9'd0;
        hc = 9'd5;
        step(40);
    endtask

    initial begin
        rst_n       = 1'b0;
        zxuno_regrd = 1'b0;
        zxuno_regwr = 1'b0;
        zxuno_addr  = 8'h00;
        din         = 8'h00;
        hc          = 9'd5;
        vc          = 9'd0;
        step(3);
        check("rst_int_n", 32'(int_n), 32'd1);
        check("rst_rip", 32'(rip), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            rd("rst_line", 8'(8'h40 + 2 * k), 8'hFF, 1'b0);
            rd("rst_ctrl", 8'(8'h41 + 2 * k), 8'h01, 1'b0);
        end
        rd("rst_status", 8'h48, 8'h00, 1'b0);
        rd("rst_gctrl", 8'h49, 8'h00, 1'b0);
        rd("unmapped_lo", 8'h3F, 8'hFF, 1'b1);
        rd("unmapped_hi", 8'h4A, 8'hFF, 1'b1);
        step(1);

        // Only the retrace fires on a reset-state frame.
        sweep(falls, lowc, vfall);
        check("frame0_pulses", 32'(falls), 32'd1);
        check("frame0_vline", 32'(vfall), 32'd248);
        check("frame0_lowcyc", 32'(lowc), 32'd32);
        check("frame0_pending", 32'(pending), 32'd0);

        // Channel 0 at line 100.
        wr(8'h40, 8'h64);
        wr(8'h41, 8'h02);
        rd("ch0_line", 8'h40, 8'h64, 1'b0);
        rd("ch0_ctrl", 8'h41, 8'h02, 1'b0);
        step(1);
        vc = 9'd100;
        hc = 9'd0;
        #1;
        check("ch0_no_comb_int", 32'(int_n), 32'd1);
        step(1);
        check("ch0_int_n", 32'(int_n), 32'd0);
        check("ch0_pending", 32'(pending), 32'd1);
        check("ch0_rip", 32'(rip), 32'd1);
        rd("ch0_status", 8'h48, 8'h01, 1'b0);
        rd("ch0_gctrl", 8'h49, 8'h80, 1'b0);
        hc = 9'd5;
        measure(w);
        check("ch0_width", 32'(w), 32'd32);
        check("ch0_rip_end", 32'(rip), 32'd0);

        // Stalled beam: one event only; clear while held stays clear.
        wr(8'h48, 8'h01);
        check("clr_pending", 32'(pending), 32'd0);
        vc = 9'd100;
        hc = 9'd0;
        step(10);
        check("hold_pending", 32'(pending), 32'd1);
        wr(8'h48, 8'h01);
        check("hold_clr", 32'(pending), 32'd0);
        measure(w);
        check("hold_width", 32'(w), 32'd22);
        lowc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!int_n) lowc++;
        end
        check("hold_no_retrigger", 32'(lowc), 32'd0);
        check("hold_pending2", 32'(pending), 32'd0);

        // Set and clear in the same cycle: set wins.
        hc = 9'd5;
        step(1);
        hc          = 9'd0;
        vc          = 9'd100;
        zxuno_addr  = 8'h48;
        din         = 8'h01;
        zxuno_regwr = 1'b1;
        step(1);
        zxuno_regwr = 1'b0;
        check("set_wins", 32'(pending), 32'd1);
        check("set_wins_int", 32'(int_n), 32'd0);
        hc = 9'd5;
        measure(w);
        check("set_wins_width", 32'(w), 32'd32);

        // Disable keeps pending; channel 1 coincident with retrace.
        wr(8'h41, 8'h00);
        check("disable_keeps", 32'(pending), 32'd1);
        wr(8'h48, 8'h0F);
        check("clr_all", 32'(pending), 32'd0);
        wr(8'h42, 8'hF8);
        wr(8'h43, 8'h02);
        vc = 9'd248;
        hc = 9'd0;
        step(1);
        check("coinc_int_n", 32'(int_n), 32'd0);
        check("coinc_rip", 32'(rip), 32'd1);
        check("coinc_pending", 32'(pending), 32'd2);
        hc = 9'd5;
        measure(w);
        check("coinc_width", 32'(w), 32'd32);
        wr(8'h43, 8'h00);
        wr(8'h48, 8'h0F);
        vc = 9'd248;
        hc = 9'd0;
        step(1);
        check("vr_int_n", 32'(int_n), 32'd0);
        check("vr_rip", 32'(rip), 32'd0);
        check("vr_pending", 32'(pending), 32'd0);
        rd("vr_gctrl", 8'h49, 8'h00, 1'b0);
        hc = 9'd5;
        measure(w);
        check("vr_width", 32'(w), 32'd32);

        // Retrace disabled, all channels off: silent frame.
        wr(8'h49, 8'h01);
        rd("gctrl_rd", 8'h49, 8'h01, 1'b0);
        step(1);
        sweep(falls, lowc, vfall);
        check("quiet_pulses", 32'(falls), 32'd0);
        check("quiet_lowcyc", 32'(lowc), 32'd0);

        // Channels 2 and 3 five cycles apart: one pulse.
        wr(8'h44, 8'h0A);
        wr(8'h45, 8'h02);
        wr(8'h46, 8'h14);
        wr(8'h47, 8'h02);
        vc = 9'd10;
        hc = 9'd0;
        step(1);
        check("ch2_int_n", 32'(int_n), 32'd0);
        check("ch2_pending", 32'(pending), 32'd4);
        hc = 9'd5;
        step(4);
        vc = 9'd20;
        hc = 9'd0;
        step(1);
        check("ch23_pending", 32'(pending), 32'd12);
        check("ch23_int_n", 32'(int_n), 32'd0);
        hc = 9'd5;
        measure(w);
        check("ch23_width", 32'(w), 32'd27);

        // Reset in the middle of a pulse.
        vc = 9'd10;
        hc = 9'd0;
        step(1);
        hc = 9'd5;
        step(5);
        check("pre_rst_int_n", 32'(int_n), 32'd0);
        rst_n = 1'b0;
        step(1);
        check("midrst_int_n", 32'(int_n), 32'd1);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_rip", 32'(rip), 32'd0);
        rst_n = 1'b1;
        rd("midrst_line2", 8'h44, 8'hFF, 1'b0);
        rd("midrst_ctrl2", 8'h45, 8'h01, 1'b0);
        rd("midrst_gctrl", 8'h49, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/rasterint_multi_ctrl.md
Name: rasterint_multi_ctrl

Overview:
- Multi-channel raster interrupt controller: NCHAN independent programmable raster-line comparators plus the vertical-retrace interrupt.
- Drives one shared active-low INT pulse to the Z80, with a per-channel pending/status register.
- Sits on the ZX-UNO register bus (zxuno_addr/regrd/regwr) beside the video timing generator, which supplies hc/vc.

Parameters:
- NCHAN, 4, number of raster comparator channels (1..8)
- BASEADDR, 8'h40, first ZX-UNO register address used by the block
- HTRIGGER, 9'd0, horizontal count at which all line matches fire
- VRETRACE_LINE, 9'd248, vc value that raises the retrace interrupt
- INT_LEN, 32, int_n low pulse width in clk cycles (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- zxuno_addr  in  8  register address
- zxuno_regrd  in  1  register read strobe
- zxuno_regwr  in  1  register write strobe
- din  in  8  write data
- dout  out  8  read data; 8'hFF when not selected
- oe_n  out  1  low when a block register is being read
- hc  in  9  current horizontal count
- vc  in  9  current vertical count
- int_n  out  1  interrupt request, active low
- raster_int_in_progress  out  1  high while the current int_n pulse was caused by a raster channel
- pending  out  NCHAN  per-channel pending flags, for debug

Behaviour:
- Clocking and reset: clk; reset rst_n is synchronous, active-low. Every state element is updated only on posedge clk.
- Reset values:
  - line_k = 9'h1FF, en_k = 0 for all channels
  - vretrace_disable = 0, pending = 0
  - FSM in IDLE, int_n = 1, raster_int_in_progress = 0
- Register map (k = 0..NCHAN-1):
  - BASEADDR+2k: line_k[7:0], read/write.
  - BASEADDR+2k+1: ctrl_k, read/write. bit0 = line_k[8], bit1 = en_k. Reads return {6'b0, en_k, line_k[8]}.
  - BASEADDR+2*NCHAN: STATUS. Read returns {zero-pad, pending}. Write: 1 clears the matching pending bit.
  - BASEADDR+2*NCHAN+1: GCTRL. bit0 = vretrace_disable. Read returns {raster_int_in_progress, 6'b0, vretrace_disable}.
  - Any other address: dout = 8'hFF, oe_n = 1.
- Register reads are combinational, same cycle as zxuno_regrd.
- Register writes take effect on the next edge.
- Match detection:
  - match_k = en_k & (vc == line_k) & (hc == HTRIGGER).
  - match_v = ~vretrace_disable & (vc == VRETRACE_LINE) & (hc == HTRIGGER).
  - Each match signal is registered. An event is the rising edge only (match & ~match_q), so a stalled hc/vc gives one event, not repeats.
- Pending:
  - A channel event sets pending_k on the same edge it is detected.
  - A set and a STATUS write-1-clear in the same cycle: set wins.
  - Disabling a channel (en_k = 0) does not clear its pending bit.
- Pulse FSM, states IDLE and ACTIVE, with a counter of width clog2(INT_LEN+1):
  - IDLE -> ACTIVE on any event (channel or retrace). int_n goes low at the next edge, i.e. 1 clk latency from the match cycle.
  - raster_int_in_progress is loaded to 1 if any channel event is in that cycle, else 0.
  - ACTIVE holds for exactly INT_LEN cycles, then returns to IDLE with int_n = 1 and raster_int_in_progress = 0.
  - Events during ACTIVE do not retrigger or extend the pulse. Channel events still set pending.
- Channel and retrace events in the same cycle: a single pulse, with raster_int_in_progress = 1.
- Several channels programmed to the same line: all of their pending bits set, one pulse.
- line_k beyond the frame height (e.g. 0x1FF): never matches, so no event. This is not an error.
- Reset while ACTIVE: int_n returns high on the reset edge and all state is cleared.

Decomposition:
- Shared package holds:
  - register offset constants (LINE_OFS = 0, CTRL_OFS = 1, STATUS_OFS = 2*NCHAN, GCTRL_OFS = 2*NCHAN+1)
  - ctrl and GCTRL bit-position constants
  - the FSM state encoding
- One sub-module, rasterint_channel: line/enable registers, match register and edge detect. It is instantiated NCHAN times through a generate loop.
- Top level keeps the pending register, pulse FSM and read mux.

Test Plan:
- Reset -> all ctrl reads return 8'h01, line reads return 8'hFF, STATUS = 0, int_n = 1; sweep full frame -> no int_n pulse except retrace.
- Write 0x40 = 8'h64, 0x41 = 8'h02; drive vc = 100, hc = 0 -> pending[0] = 1 and int_n low 1 clk later for exactly 32 clks, raster_int_in_progress = 1; read 0x48 returns 8'h01.
- Hold vc = 100, hc = 0 for 10 clks -> only one event and one pulse; write 0x48 = 8'h01 -> pending[0] = 0; clear on the same cycle as a new event -> pending stays 1.
- Channel 1 line = 248 enabled, vretrace enabled, vc = 248, hc = 0 -> single 32-clk pulse, raster_int_in_progress = 1, pending = 4'b0010; with channel 1 disabled -> pulse with raster_int_in_progress = 0.
- GCTRL write 8'h01 and all channels disabled, sweep full frame -> int_n stays 1; GCTRL read returns 8'h01.
- Channel 2 fires at cycle t and channel 3 at t+5 -> one pulse ending at t+1+32, pending = 4'b1100; assert rst_n low mid-pulse -> int_n = 1 and pending = 0 at the next edge.
